reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter XLEN, default 32: data width of each register in bits.
REQ-002 Parameter NREG, default 32: number of architectural registers; AW = clog2(NREG) is derived and is not overridable.
REQ-003 Parameter NRD, default 2: number of independent read ports.
REQ-004 Parameter ZERO_REG, default 1: when 1, register 0 reads as 0 and ignores writes; when 0, register 0 is an ordinary register.
REQ-005 One clock and an asynchronous, active-low reset; the clock port is clk and the reset port is i_rst_n.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 i_rst_n  input  1  asynchronous active-low reset.
REQ-008 i_renable  input  1  latch all read addresses at this edge.
REQ-009 rs_addr  input  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
REQ-010 i_wenable  input  1  write strobe.
REQ-011 rd_addr  input  AW  write address.
REQ-012 rd_val  input  XLEN  write data.
REQ-013 i_issue  input  1  mark a register as having a pending writer.
REQ-014 i_issue_addr  input  AW  register to mark pending.
REQ-015 rs_val  output  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
REQ-016 rs_busy  output  NRD  pending flag of the register currently addressed by each port.
REQ-017 o_busy_vec  output  NREG  the full pending scoreboard.

Function
REQ-018 Read timing:
- On a rising edge with i_renable=1, each port SHALL latch rs_addr[k].
- With i_renable=0, the latched addresses SHALL hold.
- rs_val[k] SHALL be a combinational read of the array at the latched address, giving one-cycle latency from address to data.
REQ-019 rs_val[k] SHALL be 0 when the latched address is >= NREG, or when ZERO_REG=1 and the latched address is 0.
REQ-020 Write: on a rising edge with i_wenable=1, register rd_addr SHALL take rd_val, except that the write SHALL be dropped when rd_addr >= NREG or when ZERO_REG=1 and rd_addr=0.
REQ-021 Write and address latch on the same edge: the write SHALL commit at that edge, so rs_val shows the new value in the following cycle (read-after-write, no stale data).
REQ-022 Multiple ports SHALL be able to hold the same address; every such port returns identical data.
REQ-023 Scoreboard set: on a rising edge with i_issue=1, busy[i_issue_addr] SHALL set, ignored when i_issue_addr >= NREG or when ZERO_REG=1 and i_issue_addr=0.
REQ-024 Scoreboard clear: on a rising edge with i_wenable=1 and a write that is not dropped, busy[rd_addr] SHALL clear.
REQ-025 Simultaneous issue and write to the same register on one edge: the data SHALL be written and busy SHALL end set (the new writer wins).
REQ-026 Simultaneous issue and write to different registers SHALL both take effect.
REQ-027 rs_busy[k] SHALL equal busy[latched address k], or 0 under the conditions of REQ-019.
REQ-028 o_busy_vec[i] SHALL equal busy[i]; bit 0 SHALL be constant 0 when ZERO_REG=1.
REQ-029 Throughput SHALL be one write, one issue and one read-address latch per cycle, with no stalls and no internal state machine beyond the array, address latches and scoreboard.

Reset
REQ-030 While i_rst_n=0, independent of clk, SHALL hold at 0:
- all registers;
- all latched read addresses;
- all busy bits.
Consequently rs_val, rs_busy and o_busy_vec SHALL read 0.
REQ-031 Reset asserted mid-operation SHALL discard any write, issue or latch on the same edge.
REQ-032 The first edge after release SHALL operate normally.
REQ-033 No initial-value loading other than reset SHALL be relied upon.

Verification
REQ-034 Reset then read: assert i_rst_n=0 mid-cycle with registers previously nonzero; latch addresses 5 and 31 -> rs_val=0 on both ports, o_busy_vec=0.
REQ-035 Write/read: write 0xDEADBEEF to x7; next cycle latch port0=7, port1=0 -> rs_val port0=0xDEADBEEF, port1=0; a write of 0x1234 to x0 then read of x0 -> 0.
REQ-036 Same-edge write+latch: write 0xA5A5A5A5 to x3 while latching port1=3 -> port1 shows 0xA5A5A5A5 the next cycle; i_renable=0 while x3 is rewritten to 0x1 -> port1 shows 0x1 (array read, address held).
REQ-037 Scoreboard:
- issue x9 -> o_busy_vec[9]=1 and rs_busy=1 on a port latched to 9;
- write x9 -> busy clears next cycle;
- issue and write x9 on the same edge -> busy[9]=1 and data updated.
REQ-038 Parameter sweep: NREG=16, XLEN=64, NRD=4, ZERO_REG=0:
- write 0x0123456789ABCDEF to x0 -> readable on all four ports;
- latched address 15 works;
- address range checks hold.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with registered read addresses and a
// per-register pending-writer scoreboard.
module reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                i_renable,
    input  logic [NRD*AW-1:0]   rs_addr,
    input  logic                i_wenable,
    input  logic [AW-1:0]       rd_addr,
    input  logic [XLEN-1:0]     rd_val,
    input  logic                i_issue,
    input  logic [AW-1:0]       i_issue_addr,
    output logic [NRD*XLEN-1:0] rs_val,
    output logic [NRD-1:0]      rs_busy,
    output logic [NREG-1:0]     o_busy_vec
);

    logic [XLEN-1:0] regs_q  [NREG];
    logic [XLEN-1:0] regs_d  [NREG];
    logic [AW-1:0]   raddr_q [NRD];
    logic [AW-1:0]   raddr_d [NRD];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Address names a real, writable register (out of range and hardwired x0 excluded).
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NREG) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        regs_d  = regs_q;
        busy_d  = busy_q;
        raddr_d = raddr_q;
        if (i_wenable && addr_ok(rd_addr)) begin
            regs_d[rd_addr] = rd_val;
            busy_d[rd_addr] = 1'b0;
        end
        // Issue after the clear so a new writer on the same edge wins.
        if (i_issue && addr_ok(i_issue_addr)) begin
            busy_d[i_issue_addr] = 1'b1;
        end
        if (i_renable) begin
            for (int k = 0; k < NRD; k++) begin
                raddr_d[k] = rs_addr[k*AW +: AW];
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            for (int k = 0; k < NRD; k++) begin
                raddr_q[k] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q  <= regs_d;
            raddr_q <= raddr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        rs_val  = '0;
        rs_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            if (addr_ok(raddr_q[k])) begin
                rs_val[k*XLEN +: XLEN] = regs_q[raddr_q[k]];
                rs_busy[k]             = busy_q[raddr_q[k]];
            end
        end
    end

    always_comb begin
        o_busy_vec = busy_q;
        if (ZERO_REG != 0) begin
            o_busy_vec[0] = 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: three differently parameterised instances
// driven together, checked against an array-based model of the register rules.
module tb_reg_file_mp;

    logic clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 32x32, 2 ports, x0 hardwired
    logic a_ren, a_we, a_iss;
    logic [9:0]  a_rs_addr;
    logic [4:0]  a_rd_addr, a_ia;
    logic [31:0] a_rd_val, a_bv;
    logic [63:0] a_rs_val;
    logic [1:0]  a_rs_busy;
    // Instance B: 16x64, 4 ports, x0 ordinary
    logic b_ren, b_we, b_iss;
    logic [15:0]  b_rs_addr, b_bv;
    logic [3:0]   b_rd_addr, b_ia, b_rs_busy;
    logic [63:0]  b_rd_val;
    logic [255:0] b_rs_val;
    // Instance C: 12x16, 3 ports, x0 hardwired, addresses 12..15 out of range
    logic c_ren, c_we, c_iss;
    logic [11:0] c_rs_addr, c_bv;
    logic [3:0]  c_rd_addr, c_ia;
    logic [15:0] c_rd_val;
    logic [47:0] c_rs_val;
    logic [2:0]  c_rs_busy;

    reg_file_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1)) u_a (
        .clk(clk), .i_rst_n(i_rst_n), .i_renable(a_ren), .rs_addr(a_rs_addr),
        .i_wenable(a_we), .rd_addr(a_rd_addr), .rd_val(a_rd_val),
        .i_issue(a_iss), .i_issue_addr(a_ia),
        .rs_val(a_rs_val), .rs_busy(a_rs_busy), .o_busy_vec(a_bv));

    reg_file_mp #(.XLEN(64), .NREG(16), .NRD(4), .ZERO_REG(0)) u_b (
        .clk(clk), .i_rst_n(i_rst_n), .i_renable(b_ren), .rs_addr(b_rs_addr),
        .i_wenable(b_we), .rd_addr(b_rd_addr), .rd_val(b_rd_val),
        .i_issue(b_iss), .i_issue_addr(b_ia),
        .rs_val(b_rs_val), .rs_busy(b_rs_busy), .o_busy_vec(b_bv));

    reg_file_mp #(.XLEN(16), .NREG(12), .NRD(3), .ZERO_REG(1)) u_c (
        .clk(clk), .i_rst_n(i_rst_n), .i_renable(c_ren), .rs_addr(c_rs_addr),
        .i_wenable(c_we), .rd_addr(c_rd_addr), .rd_val(c_rd_val),
        .i_issue(c_iss), .i_issue_addr(c_ia),
        .rs_val(c_rs_val), .rs_busy(c_rs_busy), .o_busy_vec(c_bv));

    int nreg_c [3] = '{32, 16, 12};
    int xlen_c [3] = '{32, 64, 16};
    int nrd_c  [3] = '{2, 4, 3};
    int zr_c   [3] = '{1, 0, 1};
    int aw_c   [3] = '{5, 4, 4};

    // Pending operation per instance, applied at the next tick
    bit          rst_op;
    bit          o_ren [3];
    int          o_ra  [3][4];
    bit          o_we  [3];
    int          o_wa  [3];
    logic [63:0] o_wd  [3];
    bit          o_iss [3];
    int          o_ia  [3];

    // Reference model state
    logic [63:0] m_reg  [3][32];
    bit          m_busy [3][32];
    int          m_lat  [3][4];

    typedef struct {
        int           d;
        string        name;
        logic [255:0] val;
        logic [3:0]   rsb;
        logic [31:0]  bv;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [63:0] mask_of(input int xl);
        if (xl >= 64) return '1;
        return (64'd1 << xl) - 64'd1;
    endfunction

    function automatic bit ok(input int d, input int a);
        return (a < nreg_c[d]) && !(zr_c[d] != 0 && a == 0);
    endfunction

    task automatic idle();
        for (int d = 0; d < 3; d++) begin
            o_ren[d] = 0; o_we[d] = 0; o_iss[d] = 0;
            o_wa[d] = 0; o_ia[d] = 0; o_wd[d] = '0;
            for (int k = 0; k < 4; k++) o_ra[d][k] = 0;
        end
    endtask

    task automatic model_step(input int d);
        if (!rst_op) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[d][i] = '0;
                m_busy[d][i] = 0;
            end
            for (int k = 0; k < 4; k++) m_lat[d][k] = 0;
            return;
        end
        if (o_we[d] && ok(d, o_wa[d])) begin
            m_reg[d][o_wa[d]] = o_wd[d] & mask_of(xlen_c[d]);
            m_busy[d][o_wa[d]] = 0;
        end
        if (o_iss[d] && ok(d, o_ia[d])) m_busy[d][o_ia[d]] = 1;
        if (o_ren[d]) begin
            for (int k = 0; k < nrd_c[d]; k++) m_lat[d][k] = o_ra[d][k];
        end
    endtask

    task automatic push_exp(input int d, input string nm);
        exp_t e;
        e.d = d; e.name = nm; e.val = '0; e.rsb = '0; e.bv = '0;
        for (int k = 0; k < nrd_c[d]; k++) begin
            if (ok(d, m_lat[d][k])) begin
                e.val = e.val | (256'(m_reg[d][m_lat[d][k]]) << (k * xlen_c[d]));
                e.rsb[k] = m_busy[d][m_lat[d][k]];
            end
        end
        for (int i = 0; i < nreg_c[d]; i++) e.bv[i] = m_busy[d][i];
        exp_q.push_back(e);
    endtask

    // Drive the pending ops mid-cycle; they take effect at the next rising edge.
    task automatic tick(input string nm);
        @(negedge clk);
        i_rst_n   = rst_op;
        a_ren     = o_ren[0]; a_we = o_we[0]; a_iss = o_iss[0];
        a_rs_addr = {5'(o_ra[0][1]), 5'(o_ra[0][0])};
        a_rd_addr = 5'(o_wa[0]); a_rd_val = 32'(o_wd[0]); a_ia = 5'(o_ia[0]);
        b_ren     = o_ren[1]; b_we = o_we[1]; b_iss = o_iss[1];
        b_rs_addr = {4'(o_ra[1][3]), 4'(o_ra[1][2]), 4'(o_ra[1][1]), 4'(o_ra[1][0])};
        b_rd_addr = 4'(o_wa[1]); b_rd_val = o_wd[1]; b_ia = 4'(o_ia[1]);
        c_ren     = o_ren[2]; c_we = o_we[2]; c_iss = o_iss[2];
        c_rs_addr = {4'(o_ra[2][2]), 4'(o_ra[2][1]), 4'(o_ra[2][0])};
        c_rd_addr = 4'(o_wa[2]); c_rd_val = 16'(o_wd[2]); c_ia = 4'(o_ia[2]);
        for (int d = 0; d < 3; d++) begin
            model_step(d);
            push_exp(d, nm);
        end
    endtask

    task automatic check(input string nm, input int d, input string what,
                         input logic [255:0] got, input logic [255:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s dut%0d %s: got %h expected %h", nm, d, what, got, want);
    endtask

    // Monitor: outputs settle just after each rising edge
    initial begin
        exp_t e;
        logic [255:0] av, ar, ab;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.d)
                    0: begin av = 256'(a_rs_val); ar = 256'(a_rs_busy); ab = 256'(a_bv); end
                    1: begin av = b_rs_val;        ar = 256'(b_rs_busy); ab = 256'(b_bv); end
                    default: begin av = 256'(c_rs_val); ar = 256'(c_rs_busy); ab = 256'(c_bv); end
                endcase
                check(e.name, e.d, "rs_val", av, e.val);
                check(e.name, e.d, "rs_busy", ar, 256'(e.rsb));
                check(e.name, e.d, "busy_vec", ab, 256'(e.bv));
            end
        end
    end

    initial begin
        idle();
        rst_op = 0;
        tick("reset"); tick("reset");
        rst_op = 1;

        // Make registers nonzero before a mid-run reset
        idle(); o_we[0] = 1; o_wa[0] = 5; o_wd[0] = 64'h55;
        o_ren[0] = 1; o_ra[0][0] = 5; o_ra[0][1] = 31;
        tick("preload");
        idle(); o_we[0] = 1; o_wa[0] = 31; o_wd[0] = 64'hFFFF_0001;
        o_iss[0] = 1; o_ia[0] = 4;
        tick("preload");
        idle(); tick("preload_read");

        // Reset mid-cycle with a write/issue/latch on the same edge
        rst_op = 0; idle();
        o_we[0] = 1; o_wa[0] = 5; o_wd[0] = 64'h7; o_iss[0] = 1; o_ia[0] = 6;
        o_ren[0] = 1; o_ra[0][0] = 9; o_ra[0][1] = 31;
        tick("reset_mid");
        rst_op = 1; idle();
        o_ren[0] = 1; o_ra[0][0] = 5; o_ra[0][1] = 31;
        tick("reset_read");

        // Write/read and hardwired x0
        idle(); o_we[0] = 1; o_wa[0] = 7; o_wd[0] = 64'hDEADBEEF; tick("wr_x7");
        idle(); o_ren[0] = 1; o_ra[0][0] = 7; o_ra[0][1] = 0; tick("rd_x7_x0");
        idle(); o_we[0] = 1; o_wa[0] = 0; o_wd[0] = 64'h1234; tick("wr_x0");
        idle(); o_ren[0] = 1; o_ra[0][0] = 0; o_ra[0][1] = 0; tick("rd_x0");

        // Same-edge write and latch, then held address sees a rewrite
        idle(); o_we[0] = 1; o_wa[0] = 3; o_wd[0] = 64'hA5A5A5A5;
        o_ren[0] = 1; o_ra[0][1] = 3; tick("raw_x3");
        idle(); o_we[0] = 1; o_wa[0] = 3; o_wd[0] = 64'h1; tick("rewrite_x3");
        idle(); tick("held_x3");

        // Scoreboard
        idle(); o_iss[0] = 1; o_ia[0] = 9; o_ren[0] = 1; o_ra[0][0] = 9; o_ra[0][1] = 9;
        tick("issue_x9");
        idle(); o_we[0] = 1; o_wa[0] = 9; o_wd[0] = 64'h99; tick("write_x9");
        idle(); o_iss[0] = 1; o_ia[0] = 9; o_we[0] = 1; o_wa[0] = 9; o_wd[0] = 64'hAB;
        tick("issue_write_x9");
        idle(); o_iss[0] = 1; o_ia[0] = 0; o_iss[1] = 1; o_ia[1] = 0; tick("issue_x0");
        idle(); o_iss[0] = 1; o_ia[0] = 10; o_we[0] = 1; o_wa[0] = 9; o_wd[0] = 64'h5;
        tick("issue_write_diff");

        // Wide instance with ordinary x0; small instance range checks
        idle(); o_we[1] = 1; o_wa[1] = 0; o_wd[1] = 64'h0123456789ABCDEF;
        o_ren[1] = 1; for (int k = 0; k < 4; k++) o_ra[1][k] = 0;
        o_we[2] = 1; o_wa[2] = 13; o_wd[2] = 64'hBEEF; o_iss[2] = 1; o_ia[2] = 14;
        tick("wide_x0");
        idle(); o_we[1] = 1; o_wa[1] = 15; o_wd[1] = 64'hFEDCBA9876543210;
        o_iss[1] = 1; o_ia[1] = 15; o_ren[1] = 1; o_ra[1][2] = 15;
        o_we[2] = 1; o_wa[2] = 11; o_wd[2] = 64'h1357; o_ren[2] = 1;
        o_ra[2][0] = 11; o_ra[2][1] = 13; o_ra[2][2] = 14;
        tick("wide_x15");
        idle(); tick("wide_hold");

        // Randomised traffic on all instances
        for (int n = 0; n < 400; n++) begin
            idle();
            rst_op = ($urandom_range(0, 99) != 0);
            for (int d = 0; d < 3; d++) begin
                o_ren[d] = ($urandom_range(0, 1) == 1);
                for (int k = 0; k < 4; k++) o_ra[d][k] = $urandom_range(0, (1 << aw_c[d]) - 1);
                o_we[d]  = ($urandom_range(0, 2) != 0);
                o_wa[d]  = $urandom_range(0, (1 << aw_c[d]) - 1);
                o_wd[d]  = {$urandom(), $urandom()};
                o_iss[d] = ($urandom_range(0, 2) == 0);
                o_ia[d]  = ($urandom_range(0, 3) == 0) ? o_wa[d]
                                                       : $urandom_range(0, (1 << aw_c[d]) - 1);
            end
            tick("random");
        end

        rst_op = 1; idle();
        tick("drain"); tick("drain");
        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
